// File: rtl/gf283_exp.sv
// GF(2^283) exponentiator, R = G^E mod (x^283 + x^12 + x^7 + x^5 + 1).
// Left-to-right square-and-multiply over a bit-serial MSB-first multiplier.
module gf283_exp (
  input  logic         clk,
  input  logic         rst,
  input  logic         go,
  input  logic [282:0] base,
  input  logic [282:0] exp,
  output logic [282:0] result,
  output logic         done,
  output logic         busy
);

  localparam int unsigned W  = 283;
  localparam int unsigned IW = 9;
  localparam logic [IW-1:0] TOP = IW'(W - 1);
  // x^283 folded back into the low terms: x^12 + x^7 + x^5 + 1
  localparam logic [W-1:0] RED = W'(13'h10A1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SQR  = 3'd1,
    MUL  = 3'd2,
    STEP = 3'd3,
    FIN  = 3'd4
  } state_t;

  state_t        state, state_nx;
  logic [W-1:0]  g_r, g_r_nx;
  logic [W-1:0]  e_r, e_r_nx;
  logic [W-1:0]  acc, acc_nx;
  logic [W-1:0]  c, c_nx;
  logic [IW-1:0] idx, idx_nx;
  logic [IW-1:0] cnt, cnt_nx;
  logic [W-1:0]  result_nx;
  logic          done_nx;
  logic          busy_nx;

  logic [W-1:0]  mul_b;
  logic [W-1:0]  c_shift;
  logic [W-1:0]  c_step;

  // One multiplier iteration: shift-and-reduce c, then add a if the current b bit is set
  always_comb begin
    mul_b   = (state == MUL) ? g_r : acc;
    c_shift = {c[W-2:0], 1'b0} ^ (c[W-1] ? RED : '0);
    c_step  = c_shift ^ (mul_b[cnt] ? acc : '0);
  end

  // Next-state and datapath update
  always_comb begin
    state_nx  = state;
    g_r_nx    = g_r;
    e_r_nx    = e_r;
    acc_nx    = acc;
    c_nx      = c;
    idx_nx    = idx;
    cnt_nx    = cnt;
    result_nx = result;
    done_nx   = 1'b0;
    busy_nx   = busy;
    unique case (state)
      IDLE: begin
        if (go) begin
          g_r_nx   = base;
          e_r_nx   = exp;
          acc_nx   = W'(1);
          c_nx     = '0;
          idx_nx   = TOP;
          cnt_nx   = TOP;
          busy_nx  = 1'b1;
          state_nx = SQR;
        end
      end
      SQR, MUL: begin
        if (cnt == '0) begin
          acc_nx = c_step;
          c_nx   = '0;
          cnt_nx = TOP;
          if (state == SQR && e_r[idx]) state_nx = MUL;
          else                          state_nx = STEP;
        end else begin
          c_nx   = c_step;
          cnt_nx = IW'(cnt - IW'(1));
        end
      end
      STEP: begin
        if (idx == '0) begin
          state_nx = FIN;
        end else begin
          idx_nx   = IW'(idx - IW'(1));
          state_nx = SQR;
        end
      end
      FIN: begin
        result_nx = acc;
        done_nx   = 1'b1;
        busy_nx   = 1'b0;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      g_r    <= '0;
      e_r    <= '0;
      acc    <= '0;
      c      <= '0;
      idx    <= '0;
      cnt    <= '0;
      result <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_nx;
      g_r    <= g_r_nx;
      e_r    <= e_r_nx;
      acc    <= acc_nx;
      c      <= c_nx;
      idx    <= idx_nx;
      cnt    <= cnt_nx;
      result <= result_nx;
      done   <= done_nx;
      busy   <= busy_nx;
    end
  end

endmodule
